// File: rtl/fsm_cpu_sender_if.sv
// Host push port plus the SEND/ACK link of the CPU-side sender, bundled as one interface.
// The sender drives the master side; the host/peripheral pair drives the slave side.
interface fsm_cpu_sender_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  push_valid;
  logic [DATA_WIDTH-1:0] push_data;
  logic                  push_ready;
  logic                  SEND;
  logic [DATA_WIDTH-1:0] outData;
  logic                  inACK;

  modport master (
    input  push_valid, push_data, inACK,
    output push_ready, SEND, outData
  );

  modport slave (
    output push_valid, push_data, inACK,
    input  push_ready, SEND, outData
  );
endinterface

// File: rtl/fsm_cpu_sender.sv
// Initiator of the SEND/ACK four-phase handshake: buffers host words in a FIFO and
// retires each one only after a full ACK rise/fall, with ACK timeout and transfer count.
module fsm_cpu_sender #(
  parameter int DATA_WIDTH     = 32,
  parameter int FIFO_DEPTH     = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  fsm_cpu_sender_if.master        bus,
  input  logic                    err_clear,
  output logic                    busy,
  output logic [15:0]             sent_count,
  output logic                    timeout_err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TO_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_LOW, RECOVER} state_t;

  state_t                state;
  state_t                state_next;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ack_s;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      fill;
  logic                  full;
  logic                  empty;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] head;

  logic                  load;
  logic                  pop;
  logic                  set_err;
  logic                  cnt_inc;
  logic                  expire;

  logic                  send_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [TO_W-1:0]       to_cnt;
  logic [15:0]           count_done;
  logic                  err_q;

  // inACK may be asynchronous; only the last synchroniser stage is ever looked at
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= bus.inACK;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign ack_s = sync_q[SYNC_STAGES-1];

  assign full           = (fill == CNT_W'(FIFO_DEPTH));
  assign empty          = (fill == '0);
  assign wr_en          = bus.push_valid && !full;
  assign head           = mem[rd_ptr];
  assign bus.push_ready = !full;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= bus.push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({wr_en, pop})
        2'b10:   fill <= fill + CNT_W'(1);
        2'b01:   fill <= fill - CNT_W'(1);
        default: fill <= fill;
      endcase
    end
  end

  assign expire = (TIMEOUT_CYCLES != 0) && (to_cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // An ACK seen in the expiry cycle takes priority over the timeout
  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (!empty && !ack_s) state_next = REQ;
      REQ: begin
        if (ack_s) begin
          state_next = WAIT_LOW;
        end else if (expire) begin
          state_next = RECOVER;
        end
      end
      WAIT_LOW: if (!ack_s) state_next = IDLE;
      RECOVER:  if (!ack_s) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    load    = 1'b0;
    pop     = 1'b0;
    set_err = 1'b0;
    cnt_inc = 1'b0;
    case (state)
      IDLE:     load = !empty && !ack_s;
      REQ: begin
        if (!ack_s) begin
          if (expire) begin
            set_err = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      WAIT_LOW: pop = !ack_s;
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      send_q     <= 1'b0;
      data_q     <= '0;
      to_cnt     <= '0;
      count_done <= '0;
      err_q      <= 1'b0;
    end else begin
      send_q <= (state_next == REQ);
      if (load) begin
        data_q <= head;
        to_cnt <= '0;
      end else if (cnt_inc) begin
        to_cnt <= to_cnt + TO_W'(1);
      end
      if (pop) begin
        count_done <= count_done + 16'd1;
      end
      if (set_err) begin
        err_q <= 1'b1;
      end else if (err_clear) begin
        err_q <= 1'b0;
      end
    end
  end

  assign bus.SEND    = send_q;
  assign bus.outData = data_q;
  assign sent_count  = count_done;
  assign timeout_err = err_q;
  assign busy        = (state != IDLE) || !empty;

endmodule
